uart_rx_param: RTL

Parametrised UART receiver, successor to the fixed 8N1 receiver behind the board top-level register-write path (address byte, then value byte).
- Supports configurable payload width, parity mode and stop-bit count.
- Reports parity, framing and break conditions alongside each received word.
- Sits between the synchronised uart_rxd pin and the byte consumer (register decoder / FIFO).

---
 rtl/uart_rx_param.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable payload width, parity, stop bits; reports perr/ferr/break.
// Optional 2-of-3 majority sampling is enabled by defining UART_RX_MAJORITY_EN.
module uart_rx_param #(
    parameter int CLK_HZ       = 50000000,
    parameter int BIT_RATE     = 115200,
    parameter int PAYLOAD_BITS = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_valid,
    output logic                    uart_rx_perr,
    output logic                    uart_rx_ferr,
    output logic                    uart_rx_break
);

    localparam int CYCLES_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int CNT_W          = $clog2(CYCLES_PER_BIT);
    localparam int BIT_W          = $clog2(PAYLOAD_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CYCLES_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_EMIT
    } state_t;

    function automatic logic parity_err(input logic [PAYLOAD_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        return (PARITY == 1) ? ~x : x;
    endfunction

    state_t                  state;
    logic [CNT_W-1:0]        cycle_cnt;
    logic [BIT_W-1:0]        bit_cnt;
    logic [PAYLOAD_BITS-1:0] data_sr;
    logic                    rxd_p0;
    logic                    rxd_s;
    logic                    rx_line;
    logic                    bit_sample;
    logic                    par_bit;
    logic                    perr_next;
    logic                    ferr_next;
    logic                    brk_next;
    logic                    brk_hold;
    logic                    shift_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_p0 <= 1'b1;
            rxd_s  <= 1'b1;
        end else begin
            rxd_p0 <= uart_rxd;
            rxd_s  <= rxd_p0;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic rxd_d1;
    logic rxd_d2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rxd_d1 <= 1'b1;
            rxd_d2 <= 1'b1;
        end else begin
            rxd_d1 <= rxd_s;
            rxd_d2 <= rxd_d1;
        end
    end

    // Bit timing follows rxd_d1, so rxd_s is the mid+1 sample and rxd_d2 the mid-1 sample.
    assign rx_line    = rxd_d1;
    assign bit_sample = maj3(rxd_d2, rxd_d1, rxd_s);
`else
    assign rx_line    = rxd_s;
    assign bit_sample = rxd_s;
`endif

    assign shift_en = uart_rx_en && (state == ST_DATA) && (cycle_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (shift_en) begin
            data_sr <= {bit_sample, data_sr[PAYLOAD_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cycle_cnt     <= '0;
            bit_cnt       <= '0;
            par_bit       <= 1'b0;
            perr_next     <= 1'b0;
            ferr_next     <= 1'b0;
            brk_next      <= 1'b0;
            brk_hold      <= 1'b0;
            uart_rx_data  <= '0;
            uart_rx_valid <= 1'b0;
            uart_rx_perr  <= 1'b0;
            uart_rx_ferr  <= 1'b0;
            uart_rx_break <= 1'b0;
        end else begin
            uart_rx_valid <= 1'b0;
            if (state != ST_IDLE && !uart_rx_en) begin
                state     <= ST_IDLE;
                cycle_cnt <= '0;
                bit_cnt   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // After a break the line must sit high for a full bit before a new start counts.
                        if (brk_hold) begin
                            if (!rx_line) begin
                                cycle_cnt <= '0;
                            end else if (cycle_cnt == CNT_LAST) begin
                                cycle_cnt <= '0;
                                brk_hold  <= 1'b0;
                            end else begin
                                cycle_cnt <= cycle_cnt + 1'b1;
                            end
                        end else if (uart_rx_en && !rx_line) begin
                            state     <= ST_START;
                            cycle_cnt <= '0;
                        end
                    end
                    ST_START: begin
                        if (cycle_cnt == CNT_MID) begin
                            cycle_cnt <= '0;
                            if (!bit_sample) begin
                                state     <= ST_DATA;
                                bit_cnt   <= '0;
                                par_bit   <= 1'b0;
                                perr_next <= 1'b0;
                                ferr_next <= 1'b0;
                                brk_next  <= 1'b0;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            cycle_cnt <= cycle_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (cycle_cnt == CNT_LAST) begin
                            cycle_cnt <= '0;
                            if (bit_cnt == DATA_LAST) begin
                                bit_cnt <= '0;
                                state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            cycle_cnt <= cycle_cnt + 1'b1;
                        end
                    end
                    ST_PARITY: begin
                        if (cycle_cnt == CNT_LAST) begin
                            cycle_cnt <= '0;
                            par_bit   <= bit_sample;
                            perr_next <= parity_err(data_sr, bit_sample);
                            state     <= ST_STOP;
                        end else begin
                            cycle_cnt <= cycle_cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (cycle_cnt == CNT_LAST) begin
                            cycle_cnt <= '0;
                            if (!bit_sample) begin
                                ferr_next <= 1'b1;
                            end
                            if (bit_cnt == '0) begin
                                brk_next <= !bit_sample && (data_sr == '0) && !par_bit;
                            end
                            if (bit_cnt == STOP_LAST) begin
                                bit_cnt <= '0;
                                state   <= ST_EMIT;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            cycle_cnt <= cycle_cnt + 1'b1;
                        end
                    end
                    ST_EMIT: begin
                        uart_rx_data  <= data_sr;
                        uart_rx_perr  <= perr_next;
                        uart_rx_ferr  <= ferr_next;
                        uart_rx_break <= brk_next;
                        uart_rx_valid <= 1'b1;
                        brk_hold      <= brk_next;
                        cycle_cnt     <= '0;
                        state         <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
